// File: rtl/ps2_key_event.sv
// PS/2 set-2 key event decoder: synchronises the Ps2_Interface byte strobe into clk and folds E0/F0 prefixes into one event.
// Optional auto-repeat suppression is enabled by defining TYPEMATIC_FILTER_EN.
module ps2_key_event #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_strobe,
    input  logic [7:0] ps2_byte,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       proto_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_BAT = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   byte_rdy_c;
    logic                   is_pfx_c;
    logic                   overrun_c;
    logic                   emit_c;
    logic                   emit_ext_c;
    logic                   emit_rel_c;
    logic                   err_c;
    logic                   suppress_c;
    logic                   fire_c;

    // Strobe synchroniser and rising-edge detector: one byte_rdy per strobe high period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_strobe};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign byte_rdy_c = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign is_pfx_c   = (ps2_byte == BYTE_EXT) || (ps2_byte == BYTE_BRK);
    assign overrun_c  = (ps2_byte == 8'h00) || (ps2_byte == 8'hFF);

    // Byte classification in the current state; a byte arriving on the timeout cycle wins
    always_comb begin
        emit_c     = 1'b0;
        emit_ext_c = 1'b0;
        emit_rel_c = 1'b0;
        err_c      = 1'b0;
        if (byte_rdy_c) begin
            if (overrun_c) begin
                err_c = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: emit_c = !is_pfx_c && (ps2_byte != BYTE_BAT);
                    ST_EXT: begin
                        emit_c     = !is_pfx_c;
                        emit_ext_c = 1'b1;
                    end
                    ST_BRK: begin
                        emit_c     = !is_pfx_c;
                        err_c      = is_pfx_c;
                        emit_rel_c = 1'b1;
                    end
                    default: begin
                        emit_c     = !is_pfx_c;
                        err_c      = is_pfx_c;
                        emit_ext_c = 1'b1;
                        emit_rel_c = 1'b1;
                    end
                endcase
            end
        end else if ((state_q != ST_IDLE) && (cnt_q == CNT_LAST)) begin
            err_c = 1'b1;
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    logic       held_valid_q;
    logic       held_ext_q;
    logic [7:0] held_code_q;
    logic       held_hit_c;

    assign held_hit_c = held_valid_q && (held_ext_q == emit_ext_c) && (held_code_q == ps2_byte);
    assign suppress_c = emit_c && !emit_rel_c && held_hit_c;

    // Last key made and not yet released; repeats of it are swallowed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= 8'h00;
        end else if (emit_c) begin
            if (!emit_rel_c) begin
                held_valid_q <= 1'b1;
                held_ext_q   <= emit_ext_c;
                held_code_q  <= ps2_byte;
            end else if (held_hit_c) begin
                held_valid_q <= 1'b0;
            end
        end
    end
`else
    assign suppress_c = 1'b0;
`endif

    assign fire_c = emit_c & ~suppress_c;

    // Prefix FSM, prefix timeout counter and registered event outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            key_valid <= fire_c;
            proto_err <= err_c;
            if (fire_c) begin
                key_code    <= ps2_byte;
                key_ext     <= emit_ext_c;
                key_release <= emit_rel_c;
            end
            if (byte_rdy_c) begin
                cnt_q <= '0;
                if (overrun_c) begin
                    state_q <= ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (ps2_byte == BYTE_EXT)      state_q <= ST_EXT;
                            else if (ps2_byte == BYTE_BRK) state_q <= ST_BRK;
                        end
                        ST_EXT: begin
                            if (ps2_byte == BYTE_BRK)      state_q <= ST_EXT_BRK;
                            else if (ps2_byte != BYTE_EXT) state_q <= ST_IDLE;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end else if (err_c || (state_q == ST_IDLE)) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed self-checking bench for ps2_key_event; prefix timeout shortened so the run stays short.
module tb_ps2_key_event;

    localparam int unsigned TO = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_strobe;
    logic [7:0] ps2_byte;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       proto_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    logic [7:0] last_code = 8'h00;
    logic last_ext = 1'b0;
    logic last_rel = 1'b0;

    ps2_key_event #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_strobe(ps2_strobe), .ps2_byte(ps2_byte),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_release(key_release), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Event monitor sampled just after each active edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rst_n) begin
            if (key_valid) begin
                ev_cnt    = ev_cnt + 1;
                last_code = key_code;
                last_ext  = key_ext;
                last_rel  = key_release;
            end
            if (proto_err) begin
                err_cnt = err_cnt + 1;
                err_cyc = cyc;
            end
            if (key_valid && proto_err) both_cnt = both_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        ps2_byte   = b;
        ps2_strobe = 1'b1;
        repeat (hold) @(negedge clk);
        ps2_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_code"}, 32'(key_code), 32'd0);
        check({tag, "_ext"}, 32'(key_ext), 32'd0);
        check({tag, "_rel"}, 32'(key_release), 32'd0);
        check({tag, "_err"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int r0;
        int c0;
        rst_n      = 1'b0;
        ps2_strobe = 1'b0;
        ps2_byte   = 8'h00;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: plain make, exact latency and one-cycle pulse
        @(negedge clk);
        ps2_byte   = 8'h1C;
        ps2_strobe = 1'b1;
        @(negedge clk);
        check("t1_lat_e0", 32'(key_valid), 32'd0);
        @(negedge clk);
        check("t1_lat_e1", 32'(key_valid), 32'd0);
        @(negedge clk);
        check("t1_valid", 32'(key_valid), 32'd1);
        check("t1_code", 32'(key_code), 32'h1C);
        check("t1_ext", 32'(key_ext), 32'd0);
        check("t1_rel", 32'(key_release), 32'd0);
        @(negedge clk);
        check("t1_pulse", 32'(key_valid), 32'd0);
        ps2_strobe = 1'b0;
        repeat (4) @(negedge clk);

        // 2: break prefix, no event on the F0 itself
        e0 = ev_cnt; r0 = err_cnt;
        send_byte(8'hF0, 3);
        check("t2_f0_noev", 32'(ev_cnt - e0), 32'd0);
        send_byte(8'h1C, 3);
        check("t2_ev", 32'(ev_cnt - e0), 32'd1);
        check("t2_code", 32'(last_code), 32'h1C);
        check("t2_ext", 32'(last_ext), 32'd0);
        check("t2_rel", 32'(last_rel), 32'd1);
        check("t2_err", 32'(err_cnt - r0), 32'd0);

        // 3: extended release E0 F0 75
        e0 = ev_cnt; r0 = err_cnt;
        send_byte(8'hE0, 3);
        send_byte(8'hF0, 3);
        send_byte(8'h75, 3);
        check("t3_ev", 32'(ev_cnt - e0), 32'd1);
        check("t3_code", 32'(last_code), 32'h75);
        check("t3_ext", 32'(last_ext), 32'd1);
        check("t3_rel", 32'(last_rel), 32'd1);
        check("t3_err", 32'(err_cnt - r0), 32'd0);

        // BAT byte in idle is silent
        e0 = ev_cnt; r0 = err_cnt;
        send_byte(8'hAA, 3);
        check("bat_ev", 32'(ev_cnt - e0), 32'd0);
        check("bat_err", 32'(err_cnt - r0), 32'd0);

        // 5: F0 F0, overrun FF, long strobe
        e0 = ev_cnt; r0 = err_cnt;
        send_byte(8'hF0, 3);
        send_byte(8'hF0, 3);
        check("t5_f0f0_err", 32'(err_cnt - r0), 32'd1);
        check("t5_f0f0_ev", 32'(ev_cnt - e0), 32'd0);
        send_byte(8'hFF, 3);
        check("t5_ff_err", 32'(err_cnt - r0), 32'd2);
        check("t5_ff_ev", 32'(ev_cnt - e0), 32'd0);
        send_byte(8'h1C, 5000);
        check("t5_long_ev", 32'(ev_cnt - e0), 32'd1);
        check("t5_long_code", 32'(last_code), 32'h1C);

        // Reset after E0 discards the prefix
        send_byte(8'hE0, 3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0 = ev_cnt;
        send_byte(8'h75, 3);
        check("rst_mid_ev", 32'(ev_cnt - e0), 32'd1);
        check("rst_mid_code", 32'(last_code), 32'h75);
        check("rst_mid_ext", 32'(last_ext), 32'd0);

        // 4: E0 then silence -> timeout error at exact cycle, then clean decode
        e0 = ev_cnt; r0 = err_cnt;
        @(negedge clk);
        c0 = cyc;
        ps2_byte   = 8'hE0;
        ps2_strobe = 1'b1;
        repeat (4) @(negedge clk);
        ps2_strobe = 1'b0;
        for (int i = 0; i < int'(TO) + 50 && err_cnt == r0; i++) @(negedge clk);
        check("t4_err", 32'(err_cnt - r0), 32'd1);
        check("t4_lat", 32'(err_cyc - c0), 32'(3 + TO));
        check("t4_noev", 32'(ev_cnt - e0), 32'd0);
        send_byte(8'h1C, 3);
        check("t4_ev", 32'(ev_cnt - e0), 32'd1);
        check("t4_ext", 32'(last_ext), 32'd0);

        // Byte lands on the timeout cycle: decoded as extended, no error
        e0 = ev_cnt; r0 = err_cnt;
        @(negedge clk);
        c0 = cyc;
        ps2_byte   = 8'hE0;
        ps2_strobe = 1'b1;
        repeat (4) @(negedge clk);
        ps2_strobe = 1'b0;
        while (cyc < c0 + int'(TO)) @(negedge clk);
        ps2_byte   = 8'h75;
        ps2_strobe = 1'b1;
        repeat (4) @(negedge clk);
        ps2_strobe = 1'b0;
        repeat (4) @(negedge clk);
        check("race_err", 32'(err_cnt - r0), 32'd0);
        check("race_ev", 32'(ev_cnt - e0), 32'd1);
        check("race_ext", 32'(last_ext), 32'd1);
        check("race_code", 32'(last_code), 32'h75);

        // 6: auto-repeat 1C 1C 1C then release
        e0 = ev_cnt;
        send_byte(8'h1C, 3);
        send_byte(8'h1C, 3);
        send_byte(8'h1C, 3);
        send_byte(8'hF0, 3);
        send_byte(8'h1C, 3);
`ifdef TYPEMATIC_FILTER_EN
        check("t6_events", 32'(ev_cnt - e0), 32'd2);
`else
        check("t6_events", 32'(ev_cnt - e0), 32'd4);
`endif
        check("t6_rel", 32'(last_rel), 32'd1);

        check("never_both", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
